// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Groups every signal that connects the two requesters and the data
// memory to the arbiter.
//   slave  modport : the arbiter (mem_port_arbiter)
//   master modport : the surroundings (requester 0, requester 1, memory)
// Signals:
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester side inputs
//   gnt0/gnt1, done0/done1, rdata0/rdata1          : requester side results
//   busy                                           : arbiter not idle
//   mem_addr, mem_we, mem_din                      : memory port drive
//   mem_dout                                       : memory read data
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
           mem_addr, mem_we, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
           mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single port of the 32 x 64-bit data memory between requester 0
// (load/store unit) and requester 1 (debug/loader). Grants round-robin,
// drives the memory for exactly one access cycle, and for loads captures
// the read data one cycle later. Every output is a register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requester handshakes + memory port)
module mem_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    READ_WAIT = 2'd2
  } state_e;

  state_e            state_q,    state_d;
  logic              prio_q,     prio_d;
  logic              winner_q,   winner_d;
  logic              gnt0_q,     gnt0_d;
  logic              gnt1_q,     gnt1_d;
  logic              done0_q,    done0_d;
  logic              done1_q,    done1_d;
  logic              busy_q,     busy_d;
  logic              mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q,  mem_din_d;
  logic [DATA_W-1:0] rdata0_q,   rdata0_d;
  logic [DATA_W-1:0] rdata1_q,   rdata1_d;
  logic              pick1;

  // Next-state and registered-output computation. The memory address and
  // data registers double as the latched request, so no separate copy of
  // addr/wdata is kept. During ACCESS mem_we_q equals the latched we.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    winner_d   = winner_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    // Port 1 wins when it is the only requester or when it holds priority.
    pick1      = bus.req1 && (!bus.req0 || prio_q);

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          winner_d   = pick1;
          prio_d     = !pick1;
          gnt0_d     = !pick1;
          gnt1_d     = pick1;
          mem_we_d   = pick1 ? bus.we1    : bus.we0;
          mem_addr_d = pick1 ? bus.addr1  : bus.addr0;
          mem_din_d  = pick1 ? bus.wdata1 : bus.wdata0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_we_q) begin
          done0_d = !winner_q;
          done1_d = winner_q;
          state_d = IDLE;
        end else begin
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (winner_q) begin
          rdata1_d = bus.mem_dout;
        end else begin
          rdata0_d = bus.mem_dout;
        end
        done0_d = !winner_q;
        done1_d = winner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy is registered, so it follows the state being entered.
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight transaction and
  // clears mem_we at once so a pending store never reaches the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      winner_q   <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      winner_q   <= winner_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.busy     = busy_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives mem_port_arbiter with a table of single transactions, a few
// hand-written multi-cycle sequences and random two-port traffic. A
// transaction-level model schedules the expected per-cycle outputs.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int MAXC   = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory: registered read, word 0 reads as zero and ignores writes.
  logic [63:0] memArr [32];
  always @(posedge clk) begin
    if (bus.mem_we && bus.mem_addr != 5'd0) memArr[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= (bus.mem_addr == 5'd0) ? 64'd0 : memArr[bus.mem_addr];
  end

  int nVec = 0;
  int nMiss = 0;
  int cyc = 0;

  // Reference model state: contents, priority, and the last busy cycle.
  logic [63:0] refMem [32];
  logic        prio;
  int          busyUntil;

  // Expected outputs scheduled per cycle.
  logic        expGnt  [2][MAXC];
  logic        expDone [2][MAXC];
  logic        expBusy [MAXC];
  logic        expWe   [MAXC];
  logic        expAddrChk [MAXC];
  logic [4:0]  expAddr [MAXC];
  logic        expDinChk [MAXC];
  logic [63:0] expDin  [MAXC];
  logic        rdNew   [2][MAXC];
  logic [63:0] rdVal   [2][MAXC];
  logic [63:0] curRd   [2];

  // Observed outputs per cycle, used by the directed sequences.
  logic        trGnt  [2][MAXC];
  logic        trDone [2][MAXC];
  logic        trWe   [MAXC];
  logic [63:0] trRd   [2][MAXC];

  // Requester agents.
  logic        agPend [2];
  logic        agWe   [2];
  logic [4:0]  agAddr [2];
  logic [63:0] agData [2];
  logic        agHold;
  logic        randomOn;

  typedef struct {
    int          port;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] wdata;
    int          gntAt;
    int          doneAt;
    int          weCnt;
    logic        chkRd;
    logic [63:0] rdata;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clearFrom(input int c);
    for (int i = c; i < MAXC; i++) begin
      expGnt[0][i] = 0; expGnt[1][i] = 0;
      expDone[0][i] = 0; expDone[1][i] = 0;
      expBusy[i] = 0; expWe[i] = 0;
      expAddrChk[i] = 0; expAddr[i] = 0;
      expDinChk[i] = 0; expDin[i] = 0;
      rdNew[0][i] = 0; rdNew[1][i] = 0;
      rdVal[0][i] = 0; rdVal[1][i] = 0;
    end
  endtask

  task automatic resetModel(input int c);
    clearFrom(c);
    prio = 1'b0;
    busyUntil = c;
    curRd[0] = 0; curRd[1] = 0;
    for (int p = 0; p < 2; p++) agPend[p] = 0;
    agHold = 0;
  endtask

  // Transaction-level model: a request seen while the arbiter is free is
  // granted next cycle; its whole timeline is written into the schedule.
  task automatic modelStep();
    int w;
    int g;
    logic we;
    logic [4:0] a;
    logic [63:0] d;
    if (rst_n && cyc > busyUntil && (bus.req0 || bus.req1)) begin
      if (bus.req0 && bus.req1) w = prio ? 1 : 0;
      else w = bus.req1 ? 1 : 0;
      prio = (w == 0);
      we = (w == 1) ? bus.we1    : bus.we0;
      a  = (w == 1) ? bus.addr1  : bus.addr0;
      d  = (w == 1) ? bus.wdata1 : bus.wdata0;
      g = cyc + 1;
      expGnt[w][g] = 1; expBusy[g] = 1; expWe[g] = we;
      expAddrChk[g] = 1; expAddr[g] = a; expDinChk[g] = 1; expDin[g] = d;
      if (we) begin
        if (a != 0) refMem[a] = d;
        expDone[w][g+1] = 1;
        busyUntil = g;
      end else begin
        expBusy[g+1] = 1; expAddrChk[g+1] = 1; expAddr[g+1] = a;
        expDone[w][g+2] = 1;
        rdNew[w][g+2] = 1;
        rdVal[w][g+2] = (a == 0) ? 64'd0 : refMem[a];
        busyUntil = g + 1;
      end
    end
  endtask

  task automatic checkOutput();
    int c;
    c = cyc;
    for (int p = 0; p < 2; p++) if (rdNew[p][c]) curRd[p] = rdVal[p][c];
    trGnt[0][c] = bus.gnt0;   trGnt[1][c] = bus.gnt1;
    trDone[0][c] = bus.done0; trDone[1][c] = bus.done1;
    trWe[c] = bus.mem_we;
    trRd[0][c] = bus.rdata0;  trRd[1][c] = bus.rdata1;
    check("gnt0", bus.gnt0, expGnt[0][c]);
    check("gnt1", bus.gnt1, expGnt[1][c]);
    check("done0", bus.done0, expDone[0][c]);
    check("done1", bus.done1, expDone[1][c]);
    check("busy", bus.busy, expBusy[c]);
    check("mem_we", bus.mem_we, expWe[c]);
    if (expAddrChk[c]) check("mem_addr", bus.mem_addr, expAddr[c]);
    if (expDinChk[c]) check("mem_din", bus.mem_din, expDin[c]);
    check("rdata0", bus.rdata0, curRd[0]);
    check("rdata1", bus.rdata1, curRd[1]);
  endtask

  task automatic driveAgents();
    for (int p = 0; p < 2; p++) begin
      if (agPend[p] && !agHold && expGnt[p][cyc]) begin
        agPend[p] = 0;
      end else if (!agPend[p] && randomOn && $urandom_range(0, 3) == 0) begin
        agPend[p] = 1;
        agWe[p]   = 1'($urandom_range(0, 1));
        agAddr[p] = 5'($urandom_range(0, 31));
        agData[p] = {$urandom, $urandom};
      end
    end
    bus.req0 = agPend[0]; bus.we0 = agWe[0]; bus.addr0 = agAddr[0]; bus.wdata0 = agData[0];
    bus.req1 = agPend[1]; bus.we1 = agWe[1]; bus.addr1 = agAddr[1]; bus.wdata1 = agData[1];
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic applyStimulus();
    if (cyc >= MAXC - 4) begin
      $display("[TB] FAIL cycle budget exceeded at cycle %0d", cyc);
      $fatal(1, "[TB] cycle budget exceeded");
    end
    driveAgents();
    @(negedge clk);
    checkOutput();
    modelStep();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic post(input int p, input logic we, input logic [4:0] a, input logic [63:0] d);
    agPend[p] = 1; agWe[p] = we; agAddr[p] = a; agData[p] = d;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    resetModel(cyc);
    repeat (2) applyStimulus();
    rst_n = 1'b1;
  endtask

  initial begin
    int t0;
    int t1;
    int gr;
    int dr;
    int wc;
    int n;
    int seq [6];

    for (int i = 0; i < 32; i++) begin memArr[i] = 0; refMem[i] = 0; end
    for (int p = 0; p < 2; p++) begin agPend[p] = 0; agWe[p] = 0; agAddr[p] = 0; agData[p] = 0; end
    agHold = 0; randomOn = 0;
    driveAgents();
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    doReset();

    // Single-transaction table from idle; timings relative to the req cycle.
    tbl[0] = '{0, 1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 1, 2, 1, 1'b0, 64'h0};
    tbl[1] = '{0, 1'b0, 5'd5,  64'h0,                   1, 3, 0, 1'b1, 64'hDEAD_BEEF_0123_4567};
    tbl[2] = '{1, 1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 1, 1'b0, 64'h0};
    tbl[3] = '{1, 1'b0, 5'd0,  64'h0,                   1, 3, 0, 1'b1, 64'h0};
    tbl[4] = '{1, 1'b1, 5'd31, 64'h0123_4567_89AB_CDEF, 1, 2, 1, 1'b0, 64'h0};
    tbl[5] = '{0, 1'b0, 5'd31, 64'h0,                   1, 3, 0, 1'b1, 64'h0123_4567_89AB_CDEF};
    tbl[6] = '{1, 1'b0, 5'd5,  64'h0,                   1, 3, 0, 1'b1, 64'hDEAD_BEEF_0123_4567};
    tbl[7] = '{0, 1'b0, 5'd7,  64'h0,                   1, 3, 0, 1'b1, 64'h0};

    for (int i = 0; i < 8; i++) begin
      t0 = cyc;
      post(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      repeat (6) applyStimulus();
      gr = -1; dr = -1; wc = 0;
      for (int k = 0; k < 6; k++) begin
        if (gr < 0 && trGnt[tbl[i].port][t0+k]) gr = k;
        if (dr < 0 && trDone[tbl[i].port][t0+k]) dr = k;
        if (trWe[t0+k]) wc++;
      end
      check($sformatf("vec%0d gnt cycle", i), 64'(gr), 64'(tbl[i].gntAt));
      check($sformatf("vec%0d done cycle", i), 64'(dr), 64'(tbl[i].doneAt));
      check($sformatf("vec%0d mem_we cycles", i), 64'(wc), 64'(tbl[i].weCnt));
      if (tbl[i].chkRd)
        check($sformatf("vec%0d rdata", i), trRd[tbl[i].port][t0+tbl[i].doneAt], tbl[i].rdata);
    end

    // Simultaneous requests after reset: port 0 first, then port 1.
    doReset();
    t0 = cyc;
    post(0, 1'b1, 5'd3, 64'hA5A5_0000_1111_5A5A);
    post(1, 1'b0, 5'd3, 64'h0);
    repeat (8) applyStimulus();
    check("simul gnt0 c1", trGnt[0][t0+1], 1);
    check("simul done0 c2", trDone[0][t0+2], 1);
    check("simul gnt1 c3", trGnt[1][t0+3], 1);
    check("simul done1 c5", trDone[1][t0+5], 1);
    check("simul rdata1", trRd[1][t0+5], 64'hA5A5_0000_1111_5A5A);
    // prio is back at 0, so port 0 wins the next tie.
    t1 = cyc;
    post(0, 1'b0, 5'd3, 64'h0);
    post(1, 1'b0, 5'd3, 64'h0);
    repeat (8) applyStimulus();
    check("prio gnt0 first", trGnt[0][t1+1], 1);
    check("prio gnt1 second", trGnt[1][t1+4], 1);
    check("prio rdata0", trRd[0][t1+3], 64'hA5A5_0000_1111_5A5A);

    // Round robin with both requests held high.
    doReset();
    agHold = 1;
    post(0, 1'b1, 5'd10, 64'h1010_1010_1010_1010);
    post(1, 1'b1, 5'd11, 64'h1111_1111_1111_1111);
    t0 = cyc;
    repeat (14) applyStimulus();
    agHold = 0; agPend[0] = 0; agPend[1] = 0;
    repeat (4) applyStimulus();
    n = 0;
    for (int k = 0; k < 6; k++) seq[k] = -1;
    for (int k = 0; k < 14; k++) begin
      if (n < 6 && trGnt[0][t0+k]) begin seq[n] = 0; n++; end
      else if (n < 6 && trGnt[1][t0+k]) begin seq[n] = 1; n++; end
    end
    for (int k = 0; k < 6; k++) check($sformatf("rr grant %0d", k), 64'(seq[k]), 64'(k % 2));

    // Reset during READ_WAIT: no done, everything cleared at once.
    post(0, 1'b0, 5'd5, 64'h0);
    repeat (4) applyStimulus();
    t0 = cyc;
    post(0, 1'b0, 5'd5, 64'h0);
    repeat (2) applyStimulus();
    check("busy before reset", bus.busy, 1);
    #1;
    rst_n = 1'b0;
    resetModel(cyc);
    #1;
    check("rst gnt0", bus.gnt0, 0);
    check("rst done0", bus.done0, 0);
    check("rst busy", bus.busy, 0);
    check("rst mem_we", bus.mem_we, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst mem_din", bus.mem_din, 0);
    check("rst rdata0", bus.rdata0, 0);
    check("rst rdata1", bus.rdata1, 0);
    repeat (3) applyStimulus();
    check("no done after reset", trDone[0][t0+3], 0);
    rst_n = 1'b1;
    repeat (2) applyStimulus();

    // Random two-port traffic against the model.
    randomOn = 1;
    repeat (2000) applyStimulus();
    randomOn = 0;
    repeat (20) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the 32 x 64-bit data memory. It shares the memory's single address/write-enable/data port between requester 0 (load/store unit) and requester 1 (debug/loader port). It grants round-robin and drives the memory for exactly one access cycle, then captures read data one cycle later and returns it with a done pulse. It sits between the requesters and the memory; the memory itself is unchanged.

## Interface
- ADDR_W, 5, memory address width (32 words; word 0 reads as 0, writes ignored by memory)
- DATA_W, 64, memory word width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, level
- we0 / we1  in  1  1 = store, 0 = load; sampled with grant
- addr0 / addr1  in  ADDR_W  word address; sampled with grant
- wdata0 / wdata1  in  DATA_W  store data; sampled with grant
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, inputs latched
- done0 / done1  out  1  one-cycle pulse: access complete
- rdata0 / rdata1  out  DATA_W  load result, valid with done, held until next load completion on that port
- busy  out  1  high whenever state != IDLE
- mem_addr  out  ADDR_W  to memory final_address
- mem_we  out  1  to memory WE_mem
- mem_din  out  DATA_W  to memory dIN
- mem_dout  in  DATA_W  from memory dout, valid the cycle after mem_addr is presented

## Operation
- States: IDLE, ACCESS, READ_WAIT. All outputs registered.
- IDLE: if neither req is high, stay. Otherwise select winner.
  - One req high: that port wins.
  - Both high: port `prio` wins.
  - On the next edge: latch winner's we/addr/wdata and winner id; pulse gnt of winner; set prio = other port; go ACCESS.
- ACCESS: mem_addr = latched addr, mem_we = latched we, mem_din = latched wdata, for exactly one cycle.
  - Store: next edge pulse done of winner, go IDLE.
  - Load: next edge go READ_WAIT.
- READ_WAIT: mem_we = 0, mem_addr held. Next edge: rdataN <= mem_dout, pulse doneN, go IDLE.
- mem_we is 0 in every state except ACCESS with a latched store.
- Requester contract: drop req in the cycle gnt is seen. A req still high in IDLE is a new transaction. Request inputs are ignored outside IDLE.
- Store to address 0 completes normally (done pulse); the memory discards the data.
- prio changes only on a grant, including single-requester grants.
- Reset (async, any state): state=IDLE, prio=0, gnt/done/mem_we/busy=0, mem_addr=0, mem_din=0, rdata0/rdata1=0. An in-flight transaction is dropped with no done. A store in ACCESS at reset is not written because mem_we clears immediately.

## Timing
- Cycle numbering: req seen at edge E0.
  - gnt high cycle 1; ACCESS cycle 1.
  - Store: written at edge E2; done cycle 2, state IDLE in cycle 2.
  - Load: READ_WAIT cycle 2; rdata/done cycle 3, state IDLE in cycle 3.
- Back-to-back: next grant at the edge ending the done cycle. Store occupancy 2 cycles, load 3 cycles.
- gnt and done never both high on the same port in one cycle; at most one of gnt0/gnt1 and one of done0/done1 high per cycle.
- Latency is fixed and independent of the other port; the losing requester waits one full transaction.

## Test plan
- Reset mid-load: rst_n low during READ_WAIT -> no done; all outputs 0 within the same cycle; busy=0.
- Single store then load, port 0: store addr 5 data 64'hDEAD_BEEF_0123_4567 -> gnt0 cycle 1, mem_we=1 cycle 1 only, done0 cycle 2. Load addr 5 -> done0 cycle 3 with rdata0=64'hDEAD_BEEF_0123_4567.
- Simultaneous requests after reset: req0 store addr 3, req1 load addr 3 -> port 0 granted first, then port 1. rdata1 equals the value port 0 stored. prio ends at 0.
- Round-robin fairness: both req held continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; no port starved.
- Address 0 store: port 1 stores 64'hFFFF..F to addr 0 -> done1 cycle 2; subsequent load addr 0 returns 0.
